// File: rtl/tcm_pkg.sv
// Shared types for the run-time timing check monitor.
// FSM states, violation kind bit positions and helpers.
package tcm_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        HOLD_WIN
    } tcm_state_e;

    localparam int KIND_SETUP = 0;
    localparam int KIND_HOLD  = 1;
    localparam int KIND_WIDTH = 2;
    localparam int KIND_W     = 3;

    typedef logic [KIND_W-1:0] viol_kind_t;

    function automatic logic [1:0] kind_pop(viol_kind_t k);
        return {1'b0, k[KIND_SETUP]}
             + {1'b0, k[KIND_HOLD]}
             + {1'b0, k[KIND_WIDTH]};
    endfunction

endpackage

// File: rtl/timing_check_monitor_if.sv
// Monitored signals, limits and violation reporting bundle.
// master drives the observed signals/config, slave is the monitor.
interface timing_check_monitor_if #(
    parameter int CNT_W  = 8,
    parameter int VCNT_W = 16
);
    import tcm_pkg::*;

    logic              data_i;
    logic              ref_i;
    logic              ref_neg_i;
    logic              cond_i;
    logic [CNT_W-1:0]  cfg_setup_i;
    logic [CNT_W-1:0]  cfg_hold_i;
    logic [CNT_W-1:0]  cfg_width_i;
    logic              viol_clr_i;
    logic              notifier_o;
    logic              viol_valid_o;
    viol_kind_t        viol_kind_o;
    logic [VCNT_W-1:0] viol_count_o;

    modport master (
        output data_i, ref_i, ref_neg_i, cond_i,
        output cfg_setup_i, cfg_hold_i, cfg_width_i,
        output viol_clr_i,
        input  notifier_o, viol_valid_o,
        input  viol_kind_o, viol_count_o
    );

    modport slave (
        input  data_i, ref_i, ref_neg_i, cond_i,
        input  cfg_setup_i, cfg_hold_i, cfg_width_i,
        input  viol_clr_i,
        output notifier_o, viol_valid_o,
        output viol_kind_o, viol_count_o
    );

endinterface

// File: rtl/tcm_edge_det.sv
// Samples one monitored signal and emits rise/fall/change pulses.
// TCM_SYNC_EN adds a 2-flop synchronizer ahead of the sample flop.
module tcm_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic q,
    output logic rise,
    output logic fall,
    output logic chg
);

    logic s_in;
    logic qq;

`ifdef TCM_SYNC_EN
    logic [1:0] sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[0], din};
        end
    end

    assign s_in = sync_q[1];
`else
    assign s_in = din;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q  <= 1'b0;
            qq <= 1'b0;
        end else begin
            q  <= s_in;
            qq <= q;
        end
    end

    assign rise = q & ~qq;
    assign fall = ~q & qq;
    assign chg  = q ^ qq;

endmodule

// File: rtl/timing_check_monitor.sv
// Run-time setup/hold/width checker with toggling notifier.
// Define TCM_SYNC_EN to synchronize data_i/ref_i (+2 cycles latency).
module timing_check_monitor
    import tcm_pkg::*;
#(
    parameter int CNT_W  = 8,
    parameter int VCNT_W = 16
) (
    input  logic clk,
    input  logic rst,
    timing_check_monitor_if.slave bus
);

    localparam logic [VCNT_W+1:0] CNT_MAX =
        {2'b00, {VCNT_W{1'b1}}};

    logic d_q, d_rise, d_fall, d_chg;
    logic r_q, r_rise, r_fall, r_chg;
    logic unused_edges;

    tcm_edge_det u_data_edge (
        .clk  (clk),
        .rst  (rst),
        .din  (bus.data_i),
        .q    (d_q),
        .rise (d_rise),
        .fall (d_fall),
        .chg  (d_chg)
    );

    tcm_edge_det u_ref_edge (
        .clk  (clk),
        .rst  (rst),
        .din  (bus.ref_i),
        .q    (r_q),
        .rise (r_rise),
        .fall (r_fall),
        .chg  (r_chg)
    );

    assign unused_edges = ^{d_q, d_rise, d_fall, r_chg};

    logic act_edge, trl_edge, act_lvl, edge_chk;

    assign act_edge = bus.ref_neg_i ? r_fall : r_rise;
    assign trl_edge = bus.ref_neg_i ? r_rise : r_fall;
    assign act_lvl  = r_q ^ bus.ref_neg_i;
    assign edge_chk = act_edge & bus.cond_i;

    logic [CNT_W-1:0] stab_cnt;
    logic [CNT_W:0]   stab_el;
    logic             setup_bad;

    // A change seen in the edge cycle means zero cycles of stability.
    assign stab_el   = d_chg ? '0
                     : {1'b0, stab_cnt} + (CNT_W+1)'(1);
    assign setup_bad = {1'b0, bus.cfg_setup_i} > stab_el;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stab_cnt <= '0;
        end else if (d_chg) begin
            stab_cnt <= '0;
        end else if (stab_cnt != '1) begin
            stab_cnt <= stab_cnt + CNT_W'(1);
        end
    end

    tcm_state_e       state_q, state_d;
    logic [CNT_W-1:0] hold_cnt, hold_cnt_d;
    logic [CNT_W:0]   hold_el;
    logic             setup_v, hold_v, hold_off;

    assign hold_el  = {1'b0, hold_cnt} + (CNT_W+1)'(1);
    assign hold_off = bus.cfg_hold_i == '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            hold_cnt <= '0;
        end else begin
            state_q  <= state_d;
            hold_cnt <= hold_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt;
        setup_v    = 1'b0;
        hold_v     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (d_chg) begin
                    state_d = ARMED;
                end
            end
            ARMED: begin
                if (edge_chk) begin
                    setup_v    = setup_bad;
                    hold_cnt_d = '0;
                    state_d    = hold_off ? ARMED : HOLD_WIN;
                end
            end
            HOLD_WIN: begin
                if (edge_chk) begin
                    setup_v    = setup_bad;
                    hold_cnt_d = '0;
                    state_d    = hold_off ? ARMED : HOLD_WIN;
                end else if (d_chg &&
                             hold_el < {1'b0, bus.cfg_hold_i}) begin
                    hold_v  = 1'b1;
                    state_d = ARMED;
                end else if (hold_el >= {1'b0, bus.cfg_hold_i}) begin
                    state_d = ARMED;
                end else begin
                    hold_cnt_d = hold_el[CNT_W-1:0];
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    logic [CNT_W-1:0] wid_cnt;
    logic             wid_arm;
    logic             width_v;

    // wid_arm blocks a trailing edge that had no matching active edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wid_cnt <= '0;
            wid_arm <= 1'b0;
        end else if (act_edge) begin
            wid_cnt <= CNT_W'(1);
            wid_arm <= 1'b1;
        end else if (trl_edge) begin
            wid_arm <= 1'b0;
        end else if (act_lvl && wid_cnt != '1) begin
            wid_cnt <= wid_cnt + CNT_W'(1);
        end
    end

    assign width_v = trl_edge & wid_arm & (wid_cnt < bus.cfg_width_i);

    viol_kind_t        kind;
    logic [VCNT_W+1:0] cnt_sum;
    logic              notifier_q, valid_q;
    viol_kind_t        kind_q;
    logic [VCNT_W-1:0] count_q;

    always_comb begin
        kind             = '0;
        kind[KIND_SETUP] = setup_v;
        kind[KIND_HOLD]  = hold_v;
        kind[KIND_WIDTH] = width_v;
    end

    assign cnt_sum = (bus.viol_clr_i ? '0 : {2'b00, count_q})
                   + (VCNT_W+2)'(kind_pop(kind));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            notifier_q <= 1'b0;
            valid_q    <= 1'b0;
            kind_q     <= '0;
            count_q    <= '0;
        end else begin
            notifier_q <= notifier_q ^ (|kind);
            valid_q    <= |kind;
            kind_q     <= kind;
            count_q    <= (cnt_sum > CNT_MAX) ? CNT_MAX[VCNT_W-1:0]
                                              : cnt_sum[VCNT_W-1:0];
        end
    end

    assign bus.notifier_o   = notifier_q;
    assign bus.viol_valid_o = valid_q;
    assign bus.viol_kind_o  = kind_q;
    assign bus.viol_count_o = count_q;

endmodule
